// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_NUM_CS_DEF = 4;
  localparam int SPI_DIV_W_DEF  = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period down-counter: emits a one-cycle tick every clk_div+1 enabled cycles.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tick ? reload_val : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one full-duplex MSB-first word per start, all four modes.
//
// state | meaning
// IDLE  | lines parked, waiting for start
// SETUP | cs_n asserted, one half-period before first sclk edge
// XFER  | 2*DATA_W sclk toggles, shift out / capture in
// HOLD  | one half-period after last edge, then release cs_n and pulse done
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int NUM_CS = SPI_NUM_CS_DEF,
  parameter int DIV_W  = SPI_DIV_W_DEF,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int TGL_W = $clog2(2 * DATA_W + 1);
  localparam logic [TGL_W-1:0] TGL_LAST = TGL_W'(2 * DATA_W);

  spi_state_t state, state_nxt;

  logic              cpol_q, cpha_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [TGL_W-1:0]  tgl_cnt, tgl_k;
  logic [NUM_CS-1:0] cs_dec_n;
  logic              tick, accept, last_tgl, capture;

  assign accept   = (state == IDLE) && start;
  assign tgl_k    = tgl_cnt + 1'b1;
  assign last_tgl = (tgl_k == TGL_LAST);
  // Odd toggles are leading edges; cpha picks which edge kind samples miso.
  assign capture  = tgl_k[0] ^ cpha_q;

  always_comb begin
    cs_dec_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) cs_dec_n[i] = 1'b0;
    end
  end

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .en         (state != IDLE),
    .load_val   (clk_div),
    .reload_val (div_q),
    .tick       (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = XFER;
      XFER:    if (tick && last_tgl) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      tgl_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            div_q   <= clk_div;
            // cpha=0 puts the MSB on mosi now, so the shifter starts one bit ahead.
            tx_sh   <= cpha ? tx_data : (tx_data << 1);
            sclk    <= cpol;
            busy    <= 1'b1;
            cs_n    <= cs_dec_n;
            tgl_cnt <= '0;
            if (!cpha) mosi <= tx_data[DATA_W-1];
          end else begin
            sclk <= cpol_q;
          end
        end
        XFER: begin
          if (tick) begin
            sclk    <= ~sclk;
            tgl_cnt <= tgl_k;
            if (capture) begin
              rx_sh <= {rx_sh[DATA_W-2:0], miso};
            end else if (!last_tgl) begin
              mosi  <= tx_sh[DATA_W-1];
              tx_sh <= tx_sh << 1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= '1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            mosi    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: per-cycle reference model plus directed transfers.
module tb_spi_master_param;
  localparam int DW   = 8;
  localparam int NCS  = 4;
  localparam int DIVW = 8;
  localparam int CSW  = 3;

  logic            clk, rst_n, start, cpol, cpha, miso, sclk, mosi, busy, done;
  logic [CSW-1:0]  cs_sel;
  logic [DIVW-1:0] clk_div;
  logic [DW-1:0]   tx_data, rx_data;
  logic [NCS-1:0]  cs_n;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  bit          loop_en;
  logic [DW-1:0] slv_word, s_rx;
  logic        slv_miso, s_cpha;

  assign miso = loop_en ? mosi : slv_miso;

  spi_master_param #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIVW), .CS_W(CSW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: outputs as a function of cycles elapsed since the accept edge.
  bit            m_active = 0;
  bit            m_busy_prev;
  int            m_n, m_H, m_L, m_sel, e_cnt, e_idx;
  logic          m_cpol = 1'b0, m_cpha;
  logic [DW-1:0] m_tx, m_exp_rx, m_rx = '0;
  logic          e_busy, e_done, e_sclk, e_mosi;
  logic [NCS-1:0] e_cs;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_rx     = '0;
      m_cpol   = 1'b0;
    end else begin
      m_busy_prev = m_active && (m_n < m_L);
      if (!m_busy_prev && start) begin
        m_active = 1;
        m_n      = 0;
        m_H      = int'(clk_div) + 1;
        m_L      = m_H * (2 * DW + 2);
        m_cpol   = cpol;
        m_cpha   = cpha;
        m_tx     = tx_data;
        m_sel    = int'(cs_sel);
        m_exp_rx = loop_en ? tx_data : slv_word;
      end else if (m_active) begin
        m_n++;
      end
    end
    #1;
    e_busy = 0; e_done = 0; e_sclk = m_cpol; e_mosi = 0; e_cs = '1;
    if (rst_n && m_active && m_n < m_L) begin
      e_busy = 1;
      if (m_sel < NCS) e_cs[m_sel] = 1'b0;
      e_cnt = m_n / m_H - 1;
      if (e_cnt < 0) e_cnt = 0;
      if (e_cnt > 2 * DW) e_cnt = 2 * DW;
      e_sclk = m_cpol ^ (e_cnt % 2 == 1);
      if (!m_cpha) begin
        e_idx = e_cnt / 2;
        if (e_idx > DW - 1) e_idx = DW - 1;
        e_mosi = m_tx[DW-1-e_idx];
      end else if (e_cnt > 0) begin
        e_idx = (e_cnt + 1) / 2 - 1;
        e_mosi = m_tx[DW-1-e_idx];
      end
    end else if (rst_n && m_active && m_n == m_L) begin
      e_done = 1;
      m_rx   = m_exp_rx;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("sclk", sclk, e_sclk);
    chk("mosi", mosi, e_mosi);
    chk("cs_n", cs_n, e_cs);
    chk("rx_data", rx_data, m_rx);
  end

  // Slave: shifts slv_word out on the non-sampling edge, captures mosi on the sampling edge.
  logic s_busy_prev = 1'b0, s_sclk_prev = 1'b0;
  int   s_edge, s_bit;
  always @(posedge clk) begin
    #1;
    if (busy && !s_busy_prev) begin
      s_edge = 0;
      s_rx   = '0;
      if (!s_cpha) begin
        slv_miso = slv_word[DW-1];
        s_bit    = 1;
      end else begin
        s_bit = 0;
      end
    end else if (busy && sclk !== s_sclk_prev) begin
      s_edge++;
      if ((s_edge % 2 == 1) ^ s_cpha) begin
        s_rx = {s_rx[DW-2:0], mosi};
      end else if (s_bit < DW) begin
        slv_miso = slv_word[DW-1-s_bit];
        s_bit++;
      end
    end
    s_busy_prev = busy;
    s_sclk_prev = sclk;
  end

  int t_acc;

  task automatic start_xfer(input logic [1:0] mode, input logic [DIVW-1:0] div,
                            input logic [DW-1:0] tx, input logic [CSW-1:0] sel,
                            input bit lp, input logic [DW-1:0] sw);
    @(negedge clk);
    cpol = mode[1]; cpha = mode[0]; clk_div = div; tx_data = tx; cs_sel = sel;
    loop_en = lp; slv_word = sw; s_cpha = mode[0];
    start = 1'b1;
    t_acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) break;
    end
    chk({nm, "_done_seen"}, done, 1'b1);
    chk({nm, "_latency"}, cyc - t_acc, exp_lat);
  endtask

  int d0, tog;
  logic sprev;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; cpol = 0; cpha = 0; cs_sel = '0; clk_div = '0;
    tx_data = '0; loop_en = 1; slv_word = '0; slv_miso = 0; s_cpha = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_mosi", mosi, 1'b0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Mode 0, H=1, loopback
    start_xfer(SPI_MODE0_TB(), 8'd0, 8'hA5, 3'd0, 1, 8'h00);
    chk("m0_cs_n", cs_n, 4'b1110);
    wait_done("m0", 18);
    chk("m0_rx", rx_data, 8'hA5);
    chk("m0_busy_low", busy, 1'b0);

    // Mode 3, H=4, slave returns C3
    start_xfer(2'b11, 8'd3, 8'h3C, 3'd0, 0, 8'hC3);
    wait_done("m3", 72);
    chk("m3_rx", rx_data, 8'hC3);
    chk("m3_slave_rx", s_rx, 8'h3C);
    chk("m3_sclk_idle", sclk, 1'b1);

    // Modes 1 and 2, slave sends 96
    start_xfer(2'b01, 8'd1, 8'h55, 3'd1, 0, 8'h96);
    wait_done("m1", 36);
    chk("m1_rx", rx_data, 8'h96);
    chk("m1_slave_rx", s_rx, 8'h55);
    start_xfer(2'b10, 8'd2, 8'hE1, 3'd3, 0, 8'h96);
    wait_done("m2", 54);
    chk("m2_rx", rx_data, 8'h96);
    chk("m2_slave_rx", s_rx, 8'hE1);

    // Ignored mid-transfer start, then back-to-back start in the done cycle
    @(negedge clk);
    d0 = done_cnt;
    start_xfer(2'b00, 8'd0, 8'h81, 3'd0, 1, 8'h00);
    repeat (6) @(negedge clk);
    tx_data = 8'hFF; cs_sel = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b1", 18);
    chk("b2b1_rx", rx_data, 8'h81);
    chk("b2b_gap_cs_n", cs_n, 4'b1111);
    tx_data = 8'h6E; cs_sel = 3'd2; start = 1'b1;
    t_acc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b2_cs_n", cs_n, 4'b1011);
    wait_done("b2b2", 18);
    chk("b2b2_rx", rx_data, 8'h6E);
    @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 2);

    // Reset at the 5th sclk toggle
    start_xfer(2'b00, 8'd1, 8'hF0, 3'd3, 1, 8'h00);
    tog = 0;
    sprev = sclk;
    for (int i = 0; i < 200 && tog < 5; i++) begin
      @(posedge clk);
      #1;
      if (sclk !== sprev) tog++;
      sprev = sclk;
    end
    chk("rst_mid_sclk_before", sclk, 1'b1);
    d0 = done_cnt;
    #1 rst_n = 0;
    #1;
    chk("rst_mid_cs_n", cs_n, 4'b1111);
    chk("rst_mid_sclk", sclk, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    start_xfer(2'b00, 8'd0, 8'h5A, 3'd0, 1, 8'h00);
    wait_done("post_rst", 18);
    chk("post_rst_rx", rx_data, 8'h5A);

    // Out-of-range chip select
    start_xfer(2'b00, 8'd2, 8'h33, 3'd5, 1, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("cs5_cs_n", cs_n, 4'b1111);
    chk("cs5_busy", busy, 1'b1);
    wait_done("cs5", 54);
    chk("cs5_rx", rx_data, 8'h33);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic [1:0] SPI_MODE0_TB();
    return 2'b00;
  endfunction

endmodule
